mul_div_unit: RTL

//  Iterative multiply/divide unit implementing the RV M-extension ops beside the single-cycle alu in EX.

---
 rtl/mul_div_unit.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//   Iterative multiply/divide unit for the RV M-extension ops, sitting beside
//   the single-cycle ALU in EX. One op in flight; the destination tag travels
//   with the op so writeback knows where the result goes.
//   Multiply: radix-2 shift-add on operand magnitudes (one bit per cycle).
//   Divide:   restoring division on magnitudes (one quotient bit per cycle).
//
//   Optional build macro: MDU_FAST_SPECIAL_EN
//     When defined, divide-by-zero, signed divide overflow and multiply by
//     zero skip iteration and complete one cycle after accept. Results are
//     identical either way.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_valid / o_ready       issue handshake (o_ready high only in IDLE)
//   i_op                    MUL=0 MULH=1 MULHSU=2 MULHU=3 DIV=4 DIVU=5 REM=6 REMU=7
//   i_rs1, i_rs2            multiplicand/dividend, multiplier/divisor
//   i_tag                   destination tag
//   i_flush                 discard in-flight op
//   o_valid / i_ready       writeback handshake
//   o_result, o_tag         result and its tag (held while stalled)
//   o_busy                  high while an op is in BUSY or DONE
// ---------------------------------------------------------------------------
module mul_div_unit #(
    parameter int REG_WIDTH = 32,
    parameter int TAG_WIDTH = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [2:0]           i_op,
    input  logic [REG_WIDTH-1:0] i_rs1,
    input  logic [REG_WIDTH-1:0] i_rs2,
    input  logic [TAG_WIDTH-1:0] i_tag,
    input  logic                 i_flush,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [REG_WIDTH-1:0] o_result,
    output logic [TAG_WIDTH-1:0] o_tag,
    output logic                 o_busy
);

    localparam int                   CNT_W    = $clog2(REG_WIDTH) + 1;
    localparam logic [CNT_W-1:0]     CNT_INIT = CNT_W'(REG_WIDTH);
    localparam logic [REG_WIDTH-1:0] MIN_VAL  = {1'b1, {(REG_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    typedef enum logic [2:0] {
        OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3,
        OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM    = 3'd6, OP_REMU  = 3'd7
    } mdu_op_t;

    function automatic logic [REG_WIDTH-1:0] f_neg(input logic en, input logic [REG_WIDTH-1:0] v);
        return en ? (~v + 1'b1) : v;
    endfunction

    state_t                 r_state, w_state_nx;
    logic [CNT_W-1:0]       r_cnt;
    mdu_op_t                r_op;
    logic [TAG_WIDTH-1:0]   r_tag;
    logic                   r_neg;
    logic [REG_WIDTH-1:0]   r_hi, r_lo, r_d;
    logic [REG_WIDTH-1:0]   r_result;
    logic [TAG_WIDTH-1:0]   r_tag_out;

    mdu_op_t                w_op;
    logic                   w_div, w_s1, w_s2, w_a_neg, w_b_neg, w_b_zero, w_neg_in;
    logic [REG_WIDTH-1:0]   w_a_mag, w_b_mag;
    logic                   w_accept, w_finish, w_special;
    logic [REG_WIDTH-1:0]   w_spec_res;
    logic [REG_WIDTH:0]     w_sum, w_shift, w_diff;
    logic                   w_qbit;
    logic [REG_WIDTH-1:0]   w_hi_nx, w_lo_nx, w_final;
    logic [2*REG_WIDTH-1:0] w_prod, w_prod_s;

    // Issue decode: operand signedness and magnitudes
    assign w_op     = mdu_op_t'(i_op);
    assign w_div    = i_op[2];
    assign w_s1     = (w_op == OP_MUL) || (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                      (w_op == OP_DIV) || (w_op == OP_REM);
    assign w_s2     = (w_op == OP_MUL) || (w_op == OP_MULH) ||
                      (w_op == OP_DIV) || (w_op == OP_REM);
    assign w_a_neg  = w_s1 && i_rs1[REG_WIDTH-1];
    assign w_b_neg  = w_s2 && i_rs2[REG_WIDTH-1];
    assign w_a_mag  = f_neg(w_a_neg, i_rs1);
    assign w_b_mag  = f_neg(w_b_neg, i_rs2);
    assign w_b_zero = (i_rs2 == '0);
    assign w_accept = i_valid && (r_state == S_IDLE) && !i_flush;
    assign w_finish = (r_state == S_BUSY) && (r_cnt == CNT_W'(1)) && !i_flush;

    // Sign applied to the final magnitude. A zero divisor must leave the
    // all-ones quotient un-negated; the remainder always follows the dividend.
    always_comb begin
        w_neg_in = w_a_neg ^ w_b_neg;
        case (w_op)
            OP_DIV, OP_DIVU: w_neg_in = (w_a_neg ^ w_b_neg) && !w_b_zero;
            OP_REM, OP_REMU: w_neg_in = w_a_neg;
            default:         w_neg_in = w_a_neg ^ w_b_neg;
        endcase
    end

`ifdef MDU_FAST_SPECIAL_EN
    always_comb begin
        w_special  = 1'b0;
        w_spec_res = '0;
        if (w_div) begin
            if (w_b_zero) begin
                w_special  = 1'b1;
                w_spec_res = ((w_op == OP_DIV) || (w_op == OP_DIVU)) ? '1 : i_rs1;
            end else if (((w_op == OP_DIV) || (w_op == OP_REM)) &&
                         (i_rs1 == MIN_VAL) && (i_rs2 == '1)) begin
                w_special  = 1'b1;
                w_spec_res = (w_op == OP_DIV) ? MIN_VAL : '0;
            end
        end else if ((i_rs1 == '0) || w_b_zero) begin
            w_special  = 1'b1;
            w_spec_res = '0;
        end
    end
`else
    assign w_special  = 1'b0;
    assign w_spec_res = '0;
`endif

    // One iteration step. Multiply: {hi,lo} holds partial product with the
    // multiplier shifting out of lo. Divide: lo shifts dividend bits into the
    // partial remainder (hi) and collects quotient bits at its LSB.
    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_d} : '0);
        w_shift = {r_hi, r_lo[REG_WIDTH-1]};
        w_diff  = w_shift - {1'b0, r_d};
        w_qbit  = ~w_diff[REG_WIDTH];
        if (r_op[2]) begin
            w_hi_nx = w_qbit ? w_diff[REG_WIDTH-1:0] : w_shift[REG_WIDTH-1:0];
            w_lo_nx = {r_lo[REG_WIDTH-2:0], w_qbit};
        end else begin
            w_hi_nx = w_sum[REG_WIDTH:1];
            w_lo_nx = {w_sum[0], r_lo[REG_WIDTH-1:1]};
        end
    end

    // Result selection from the last iteration's values
    always_comb begin
        w_prod   = {w_hi_nx, w_lo_nx};
        w_prod_s = r_neg ? (~w_prod + 1'b1) : w_prod;
        case (r_op)
            OP_MUL:                       w_final = w_prod_s[REG_WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod_s[2*REG_WIDTH-1:REG_WIDTH];
            OP_DIV, OP_DIVU:              w_final = f_neg(r_neg, w_lo_nx);
            default:                      w_final = f_neg(r_neg, w_hi_nx);
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nx = w_special ? S_DONE : S_BUSY;
            S_BUSY:  if (r_cnt == CNT_W'(1)) w_state_nx = S_DONE;
            S_DONE:  if (i_ready) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
        if (i_flush) w_state_nx = S_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_result  <= '0;
            r_tag_out <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_accept) begin
                r_cnt <= CNT_INIT;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_accept && w_special) begin
                r_result  <= w_spec_res;
                r_tag_out <= i_tag;
            end else if (w_finish) begin
                r_result  <= w_final;
                r_tag_out <= r_tag;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_op  <= w_op;
            r_tag <= i_tag;
            r_neg <= w_neg_in;
            r_hi  <= '0;
            r_lo  <= w_div ? w_a_mag : w_b_mag;
            r_d   <= w_div ? w_b_mag : w_a_mag;
        end else if (r_state == S_BUSY) begin
            r_hi <= w_hi_nx;
            r_lo <= w_lo_nx;
        end
    end

    assign o_ready  = (r_state == S_IDLE);
    assign o_valid  = (r_state == S_DONE);
    assign o_busy   = (r_state != S_IDLE);
    assign o_result = r_result;
    assign o_tag    = r_tag_out;

endmodule
